song_sequencer: RTL and testbench

- Sequences the tone decoder: issues one 4-bit note index (INX) per beat, which the decoder turns into a divider preload and display code.
- Auto mode walks a song ROM at a fixed tempo. Manual mode passes keyboard notes through when no song is active.
- Sits between the key/button front end, the song ROM and the tone decoder/speaker divider.

---
 rtl/song_sequencer_pkg.sv | 15 +
 rtl/song_sequencer_beat_timer.sv | 37 +++
 rtl/song_sequencer.sv | 139 +++++++++++++
 tb/tb_song_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared mode encodings and note-index constants for the song sequencer.
// Combinational only: no latency and no flow control.
package song_sequencer_pkg;

  localparam int NOTE_W = 4;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_PLAY   = 2'b01,
    MODE_PAUSE  = 2'b10,
    MODE_MANUAL = 2'b11
  } mode_e;

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Beat timer: counts enabled cycles 0..BEAT_DIV-1 and emits a registered tick on wrap.
// Tick rises one cycle after the count reaches BEAT_DIV-1; no backpressure, EN=0 freezes the count.
module song_sequencer_beat_timer #(
  parameter int BEAT_DIV = 12500
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(BEAT_DIV - 1));
  assign o_tick = r_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= i_en && w_last;
      if (i_en) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: plays a song ROM at a fixed tempo or passes manual keys through to the tone decoder.
// INX follows a ROM address load by 2 cycles, a manual key by 1 cycle; no backpressure, commands are pulses.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int BEAT_DIV = 12500,
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 139,
  parameter int LOOP     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [3:0]        i_key,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [3:0]        i_rom_data,
  output logic [3:0]        o_inx,
  output logic              o_beat,
  output logic [1:0]        o_mode,
  output logic              o_done
);

  mode_e              r_mode, w_mode_nx;
  logic [ADDR_W-1:0]  r_addr, w_addr_nx;
  logic [NOTE_W-1:0]  r_inx, w_inx_nx;
  logic               r_v1, w_v1_nx;
  logic               r_v2, w_v2_nx;
  logic               r_done, w_done_nx;
  logic               w_tmr_en, w_tmr_clr;
  logic               w_beat;
  logic               w_last_addr;

  assign w_last_addr = (r_addr == ADDR_W'(SONG_LEN - 1));

  song_sequencer_beat_timer #(
    .BEAT_DIV(BEAT_DIV)
  ) u_beat_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_tmr_en),
    .i_clr (w_tmr_clr),
    .o_tick(w_beat)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= MODE_IDLE;
      r_addr <= '0;
      r_inx  <= NOTE_REST;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_mode <= w_mode_nx;
      r_addr <= w_addr_nx;
      r_inx  <= w_inx_nx;
      r_v1   <= w_v1_nx;
      r_v2   <= w_v2_nx;
      r_done <= w_done_nx;
    end
  end

  // r_v1/r_v2 track a fetch: v1 = address just loaded, v2 = ROM_DATA now valid.
  always_comb begin
    w_mode_nx = r_mode;
    w_addr_nx = r_addr;
    w_inx_nx  = r_inx;
    w_v1_nx   = 1'b0;
    w_v2_nx   = r_v1;
    w_done_nx = 1'b0;
    w_tmr_en  = 1'b0;
    w_tmr_clr = 1'b0;

    if (i_stop) begin
      w_mode_nx = MODE_IDLE;
      w_addr_nx = '0;
      w_inx_nx  = NOTE_REST;
      w_v2_nx   = 1'b0;
      w_tmr_clr = 1'b1;
    end else if (i_start) begin
      w_mode_nx = MODE_PLAY;
      w_addr_nx = '0;
      w_v1_nx   = 1'b1;
      w_v2_nx   = 1'b0;
      w_tmr_clr = 1'b1;
    end else begin
      case (r_mode)
        MODE_IDLE, MODE_MANUAL: begin
          w_inx_nx  = i_key;
          w_mode_nx = (i_key != NOTE_REST) ? MODE_MANUAL : MODE_IDLE;
        end
        MODE_PAUSE: begin
          if (i_pause) begin
            w_mode_nx = MODE_PLAY;
            w_v1_nx   = 1'b1;
          end
        end
        default: begin
          if (i_pause) begin
            w_mode_nx = MODE_PAUSE;
            w_inx_nx  = NOTE_REST;
            w_v2_nx   = 1'b0;
          end else begin
            w_tmr_en = 1'b1;
            if (r_v2) begin
              w_inx_nx = i_rom_data;
            end
            if (w_beat) begin
              if (!w_last_addr) begin
                w_addr_nx = r_addr + 1'b1;
                w_v1_nx   = 1'b1;
              end else if (LOOP != 0) begin
                w_addr_nx = '0;
                w_v1_nx   = 1'b1;
              end else begin
                w_mode_nx = MODE_IDLE;
                w_addr_nx = '0;
                w_inx_nx  = NOTE_REST;
                w_v2_nx   = 1'b0;
                w_done_nx = 1'b1;
                w_tmr_en  = 1'b0;
                w_tmr_clr = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign o_rom_addr = r_addr;
  assign o_inx      = r_inx;
  assign o_beat     = w_beat;
  assign o_mode     = r_mode;
  assign o_done     = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed vector table, hand-written corner sequences and random commands
// against a cycle-level behavioural model; two instances cover LOOP=0 and LOOP=1.
module tb_song_sequencer;

  localparam int BD  = 4;
  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st = 1'b0, ps = 1'b0, sp = 1'b0;
  logic [3:0] key = 4'd0;

  logic [7:0] addr0, addr1;
  logic [3:0] inx0, inx1;
  logic       beat0, beat1, done0, done1;
  logic [1:0] mode0, mode1;
  logic [3:0] rd0 = 4'd0, rd1 = 4'd0;
  logic [3:0] rom [4] = '{4'd3, 4'd5, 4'd0, 4'd9};

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state, one slot per instance (slot 1 loops).
  int m_mode [2];
  int m_addr [2];
  int m_inx  [2];
  int m_cnt  [2];
  int m_due  [2];
  int m_beat [2];
  int m_done [2];

  always #5 clk = ~clk;

  song_sequencer #(.BEAT_DIV(BD), .ADDR_W(8), .SONG_LEN(LEN), .LOOP(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(st), .i_pause(ps), .i_stop(sp), .i_key(key),
    .o_rom_addr(addr0), .i_rom_data(rd0), .o_inx(inx0), .o_beat(beat0),
    .o_mode(mode0), .o_done(done0)
  );

  song_sequencer #(.BEAT_DIV(BD), .ADDR_W(8), .SONG_LEN(LEN), .LOOP(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(st), .i_pause(ps), .i_stop(sp), .i_key(key),
    .o_rom_addr(addr1), .i_rom_data(rd1), .o_inx(inx1), .o_beat(beat1),
    .o_mode(mode1), .o_done(done1)
  );

  always @(posedge clk) begin
    rd0 <= rom[addr0[1:0]];
    rd1 <= rom[addr1[1:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_addr[i] = 0; m_inx[i] = 0; m_cnt[i] = 0;
      m_due[i] = 0; m_beat[i] = 0; m_done[i] = 0;
    end
  endtask

  // One clock edge of the song player, stated in terms of notes, beats and pending fetches.
  task automatic model_step(input logic s, input logic p, input logic x, input logic [3:0] k);
    for (int i = 0; i < 2; i++) begin
      int beat_now;
      beat_now  = m_beat[i];
      m_beat[i] = 0;
      m_done[i] = 0;
      if (x) begin
        m_mode[i] = 0; m_addr[i] = 0; m_inx[i] = 0; m_cnt[i] = 0; m_due[i] = 0;
      end else if (s) begin
        m_mode[i] = 1; m_addr[i] = 0; m_cnt[i] = 0; m_due[i] = 2;
      end else if (m_mode[i] == 0 || m_mode[i] == 3) begin
        m_inx[i]  = k;
        m_mode[i] = (k != 0) ? 3 : 0;
      end else if (m_mode[i] == 2) begin
        if (p) begin
          m_mode[i] = 1; m_due[i] = 2;
        end
      end else if (p) begin
        m_mode[i] = 2; m_inx[i] = 0; m_due[i] = 0;
      end else begin
        if (m_due[i] == 1) m_inx[i] = rom[m_addr[i]];
        if (m_due[i] > 0) m_due[i]--;
        m_beat[i] = (m_cnt[i] == BD - 1) ? 1 : 0;
        m_cnt[i]  = (m_cnt[i] + 1) % BD;
        if (beat_now != 0) begin
          if (m_addr[i] < LEN - 1) begin
            m_addr[i]++; m_due[i] = 2;
          end else if (i == 1) begin
            m_addr[i] = 0; m_due[i] = 2;
          end else begin
            m_mode[i] = 0; m_addr[i] = 0; m_inx[i] = 0; m_cnt[i] = 0;
            m_due[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_one(input string tag, input int i, input logic [7:0] a, input logic [3:0] n,
                           input logic b, input logic [1:0] m, input logic d);
    chk($sformatf("%s.u%0d.addr", tag, i), a, m_addr[i]);
    chk($sformatf("%s.u%0d.inx", tag, i), n, m_inx[i]);
    chk($sformatf("%s.u%0d.beat", tag, i), b, m_beat[i]);
    chk($sformatf("%s.u%0d.mode", tag, i), m, m_mode[i]);
    chk($sformatf("%s.u%0d.done", tag, i), d, m_done[i]);
  endtask

  task automatic check_model(input string tag);
    check_one(tag, 0, addr0, inx0, beat0, mode0, done0);
    check_one(tag, 1, addr1, inx1, beat1, mode1, done1);
  endtask

  // Apply one cycle of inputs, clock it, advance the model, compare away from the edge.
  task automatic cyc(input logic s, input logic p, input logic x, input logic [3:0] k);
    st = s; ps = p; sp = x; key = k;
    @(posedge clk);
    model_step(s, p, x, k);
    #1;
    check_model("model");
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.addr", addr0, 0);
    chk("arst.inx", inx0, 0);
    chk("arst.mode", mode0, 0);
    chk("arst.beat", beat0, 0);
    chk("arst.done", done0, 0);
    check_model("arst");
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int cyc; int dut; int addr; int inx; int beat; int mode; int done;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{2, 0, 0, 3, 0, 1, 0};
    tbl[2]  = '{4, 0, 0, 3, 1, 1, 0};
    tbl[3]  = '{5, 0, 1, 3, 0, 1, 0};
    tbl[4]  = '{7, 0, 1, 5, 0, 1, 0};
    tbl[5]  = '{8, 0, 1, 5, 1, 1, 0};
    tbl[6]  = '{9, 0, 2, 5, 0, 1, 0};
    tbl[7]  = '{11, 0, 2, 0, 0, 1, 0};
    tbl[8]  = '{13, 0, 3, 0, 0, 1, 0};
    tbl[9]  = '{15, 0, 3, 9, 0, 1, 0};
    tbl[10] = '{16, 0, 3, 9, 1, 1, 0};
    tbl[11] = '{17, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{18, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{17, 1, 0, 9, 0, 1, 0};
    tbl[14] = '{19, 1, 0, 3, 0, 1, 0};
    tbl[15] = '{20, 1, 0, 3, 1, 1, 0};

    // Reset state
    model_reset();
    @(posedge clk);
    #1;
    chk("reset.mode", mode0, 0);
    chk("reset.inx", inx0, 0);
    chk("reset.addr", addr0, 0);
    check_model("reset");
    #2 rst = 1'b0;

    // Song playback, LOOP=0 and LOOP=1 side by side
    cyc(1, 0, 0, 0);
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) cyc(0, 0, 0, 0);
      foreach (tbl[j]) begin
        if (tbl[j].cyc == c) begin
          if (tbl[j].dut == 0) begin
            chk($sformatf("vec%0d.addr", j), addr0, tbl[j].addr);
            chk($sformatf("vec%0d.inx", j), inx0, tbl[j].inx);
            chk($sformatf("vec%0d.beat", j), beat0, tbl[j].beat);
            chk($sformatf("vec%0d.mode", j), mode0, tbl[j].mode);
            chk($sformatf("vec%0d.done", j), done0, tbl[j].done);
          end else begin
            chk($sformatf("vec%0d.addr", j), addr1, tbl[j].addr);
            chk($sformatf("vec%0d.inx", j), inx1, tbl[j].inx);
            chk($sformatf("vec%0d.beat", j), beat1, tbl[j].beat);
            chk($sformatf("vec%0d.mode", j), mode1, tbl[j].mode);
            chk($sformatf("vec%0d.done", j), done1, tbl[j].done);
          end
        end
      end
    end

    // Pause mid-note, hold, resume
    cyc(1, 0, 0, 0);
    for (int c = 1; c <= 7; c++) cyc(0, 0, 0, 0);
    chk("pause.pre.addr", addr0, 1);
    chk("pause.pre.inx", inx0, 5);
    cyc(0, 1, 0, 0);
    chk("pause.mode", mode0, 2);
    chk("pause.inx", inx0, 0);
    for (int c = 0; c < 20; c++) begin
      cyc(0, 0, 0, 0);
      chk("pause.hold.addr", addr0, 1);
      chk("pause.hold.beat", beat0, 0);
      chk("pause.hold.inx", inx0, 0);
    end
    cyc(0, 1, 0, 0);
    chk("resume.mode", mode0, 1);
    chk("resume.inx0", inx0, 0);
    cyc(0, 0, 0, 0);
    chk("resume.beat", beat0, 1);
    cyc(0, 0, 0, 0);
    chk("resume.inx", inx0, 5);
    chk("resume.addr", addr0, 2);

    // Manual keys
    cyc(0, 0, 1, 0);
    chk("stop.mode", mode0, 0);
    for (int c = 0; c < 5; c++) begin
      cyc(0, 0, 0, 4'd12);
      chk("manual.mode", mode0, 3);
      chk("manual.inx", inx0, 12);
    end
    cyc(0, 0, 0, 0);
    chk("manual.rel.mode", mode0, 0);
    chk("manual.rel.inx", inx0, 0);
    cyc(1, 0, 0, 4'd7);
    chk("key_in_play.mode", mode0, 1);
    cyc(0, 0, 0, 4'd7);
    cyc(0, 0, 0, 4'd7);
    chk("key_in_play.inx", inx0, 3);

    // Coincident commands, then restart mid-song
    cyc(1, 1, 1, 0);
    chk("prio.mode", mode0, 0);
    chk("prio.inx", inx0, 0);
    chk("prio.addr", addr0, 0);
    cyc(1, 0, 0, 0);
    for (int c = 1; c <= 9; c++) cyc(0, 0, 0, 0);
    chk("restart.pre.addr", addr0, 2);
    cyc(1, 0, 0, 0);
    chk("restart.addr", addr0, 0);
    chk("restart.inx_hold", inx0, 5);
    cyc(0, 0, 0, 0);
    chk("restart.inx_hold2", inx0, 5);
    cyc(0, 0, 0, 0);
    chk("restart.inx", inx0, 3);

    // Async reset between edges
    for (int c = 0; c < 3; c++) cyc(0, 0, 0, 0);
    async_reset();
    for (int c = 0; c < 5; c++) cyc(0, 0, 0, 0);
    chk("post_rst.mode", mode0, 0);
    chk("post_rst.addr", addr0, 0);

    // Random command stream
    begin
      logic [3:0] k;
      k = 4'd0;
      for (int n = 0; n < 800; n++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if ($urandom_range(0, 9) == 0)
          k = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        cyc(r < 3, r >= 3 && r < 7, r == 7, k);
        if ($urandom_range(0, 249) == 0) async_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
